io_7seg_display: RTL and testbench

Memory-mapped I/O responder for the CPU data bus: services the LDS/STS accesses the core issues to I/O addresses $80–$84. Holds four hex digits and an LED register, returns synchronized switch state on reads, and time-multiplexes the four digits onto an active-low 7-segment display. It sits beside data RAM on the CPU's 8-bit address / 8-bit data bus and decodes its own address window.

---
 rtl/io_7seg_display.sv | 161 ++++++++++++++++
 tb/tb_io_7seg_display.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_7seg_display.sv
// io_7seg_display: memory-mapped I/O responder at $80-$84 (hex digits, switches, digit mask, LEDs)
// plus a time-multiplexed driver for an active-low 4-digit 7-segment display.
// Latency: stores land 1 cycle after the we edge; display outputs are registered (1 cycle behind idx).
// Backpressure: none; every access completes in a single cycle with no wait states.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   addr, wdata, we   CPU data bus (LDS/STS); rdata/hit are combinational from addr
//   sw                asynchronous board switches, read back through a 2-flop synchronizer at $81
//   led               LED register ($83)
//   seg, dp, an       active-low segments {g..a}, decimal point (always off), one-hot digit anodes
//
// Optional feature: define IO7SEG_MASK_EN to implement the $82 digit-enable mask.
// Without it $82 reads 0, ignores writes and all four digits are always lit in turn.

module io_7seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata,
    output logic       hit,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [7:0] A_DIG10 = 8'h80;
    localparam logic [7:0] A_SW    = 8'h81;
    localparam logic [7:0] A_MASK  = 8'h82;
    localparam logic [7:0] A_LED   = 8'h83;
    localparam logic [7:0] A_DIG32 = 8'h84;

    logic [7:0]       dig10;
    logic [7:0]       dig32;
    logic [7:0]       led_reg;
    logic [7:0]       sw_meta;
    logic [7:0]       sw_sync;
    logic [3:0]       mask_eff;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       cur_digit;
    logic             wr;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign hit = (addr >= A_DIG10) && (addr <= A_DIG32);
    assign wr  = we && hit;
    assign led = led_reg;
    assign dp  = 1'b1;

    // Bus registers and the switch synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig10   <= 8'h00;
            dig32   <= 8'h00;
            led_reg <= 8'h00;
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr && addr == A_DIG10) dig10   <= wdata;
            if (wr && addr == A_LED)   led_reg <= wdata;
            if (wr && addr == A_DIG32) dig32   <= wdata;
        end
    end

`ifdef IO7SEG_MASK_EN
    logic [3:0] mask_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= 4'hF;
        end else if (wr && addr == A_MASK) begin
            mask_reg <= wdata[3:0];
        end
    end

    assign mask_eff = mask_reg;
`else
    assign mask_eff = 4'hF;
`endif

    // Read mux; a same-cycle store is not yet visible, so the old value is returned.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            A_DIG10: rdata = dig10;
            A_SW:    rdata = sw_sync;
`ifdef IO7SEG_MASK_EN
            A_MASK:  rdata = {4'h0, mask_eff};
`endif
            A_LED:   rdata = led_reg;
            A_DIG32: rdata = dig32;
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        cur_digit = dig10[3:0];
        case (idx)
            2'd0: cur_digit = dig10[3:0];
            2'd1: cur_digit = dig10[7:4];
            2'd2: cur_digit = dig32[3:0];
            default: cur_digit = dig32[7:4];
        endcase
    end

    // Scan: cnt sets the dwell, idx picks the slot. an/seg are reloaded every cycle
    // from the current idx, so they trail idx by one cycle but keep the same dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
            an  <= 4'hF;
            seg <= 7'h7F;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A disabled digit keeps its anode high for the whole slot.
            an  <= ~(4'b0001 << idx) | ~mask_eff;
            seg <= hex_decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_io_7seg_display.sv
// tb_io_7seg_display: randomized bus/switch traffic against a reference model of the register
// map, switch delay and scan schedule (slot derived from the number of edges since reset).
// Latency/backpressure: n/a (bench).

module tb_io_7seg_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       we = 1'b0;
    logic [7:0] rdata;
    logic       hit;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    io_7seg_display #(.SCAN_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .hit   (hit),
        .sw    (sw),
        .led   (led),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] m_digit [4];
    logic [7:0] m_led;
    logic [3:0] m_mask;
    int         m_edges;
    logic [7:0] swq [$];

`ifdef IO7SEG_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    function automatic logic [7:0] model_sw();
        if (swq.size() >= 2) return swq[swq.size()-2];
        return 8'h00;
    endfunction

    function automatic bit model_hit(input logic [7:0] a);
        return (a >= 8'h80) && (a <= 8'h84);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h80: return {m_digit[1], m_digit[0]};
            8'h81: return model_sw();
            8'h82: return MASK_ON ? {4'h0, m_mask} : 8'h00;
            8'h83: return m_led;
            8'h84: return {m_digit[3], m_digit[2]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_led   = 8'h00;
        m_mask  = 4'hF;
        m_edges = 0;
        swq.delete();
    endtask

    // One bus cycle: drive, check combinational read side, clock, check registered side.
    task automatic step(input logic [7:0] a, input logic [7:0] w, input bit e, input logic [7:0] s);
        int         slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        addr = a; wdata = w; we = e; sw = s;
        #2;
        check("hit", {31'b0, hit}, {31'b0, model_hit(a)});
        check("rdata", {24'b0, rdata}, {24'b0, model_read(a)});
        slot    = (m_edges / DIV) % 4;
        exp_an  = 4'hF;
        if (m_mask[slot]) exp_an[slot] = 1'b0;
        exp_seg = hex_tab[m_digit[slot]];
        @(posedge clk);
        #1;
        swq.push_back(s);
        m_edges++;
        if (e && model_hit(a)) begin
            case (a)
                8'h80: begin m_digit[0] = w[3:0]; m_digit[1] = w[7:4]; end
                8'h82: if (MASK_ON) m_mask = w[3:0];
                8'h83: m_led = w;
                8'h84: begin m_digit[2] = w[3:0]; m_digit[3] = w[7:4]; end
                default: ;
            endcase
        end
        check("an", {28'b0, an}, {28'b0, exp_an});
        check("seg", {25'b0, seg}, {25'b0, exp_seg});
        check("dp", {31'b0, dp}, 32'd1);
        check("led", {24'b0, led}, {24'b0, m_led});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 8'h00, 1'b0, sw);
    endtask

    // Assert reset asynchronously (called just after a rising edge), hold, release.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_seg", {25'b0, seg}, 32'h7F);
        check("rst_dp", {31'b0, dp}, 32'd1);
        check("rst_led", {24'b0, led}, 32'h00);
        addr = 8'h82; we = 1'b0;
        #1;
        check("rst_mask_rd", {24'b0, rdata}, MASK_ON ? 32'h0F : 32'h00);
        for (int i = 0; i < hold; i++) @(posedge clk);
        #1;
        check("rst_hold_an", {28'b0, an}, 32'hF);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        logic [7:0] a;
        @(posedge clk);
        #1;
        do_reset(3);
        step(8'h80, 8'h00, 1'b0, 8'h00);
        check("first_an", {28'b0, an}, 32'hE);
        check("first_seg", {25'b0, seg}, 32'h40);

        // Store/load, including a write to the read-only and an unmapped address.
        step(8'h80, 8'h3A, 1'b1, 8'h00);
        step(8'h84, 8'hC5, 1'b1, 8'h00);
        step(8'h83, 8'h81, 1'b1, 8'h00);
        step(8'h81, 8'hFF, 1'b1, 8'h00);
        step(8'h90, 8'hFF, 1'b1, 8'h00);
        step(8'h80, 8'h00, 1'b0, 8'h00);
        step(8'h84, 8'h00, 1'b0, 8'h00);
        check("led_81", {24'b0, led}, 32'h81);

        // Switch synchronizer step.
        step(8'h81, 8'h00, 1'b0, 8'hA5);
        step(8'h81, 8'h00, 1'b0, 8'hA5);
        step(8'h81, 8'h00, 1'b0, 8'hA5);
        step(8'h81, 8'h00, 1'b0, 8'hA5);

        // Scan pattern {C,5,A,3} over two frames.
        step(8'h80, 8'hA3, 1'b1, sw);
        step(8'h84, 8'hC5, 1'b1, sw);
        idle(4 * DIV * 2);

        // Mask 05, then restore.
        step(8'h82, 8'h05, 1'b1, sw);
        idle(4 * DIV + 3);
        step(8'h82, 8'h0F, 1'b1, sw);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 9);
            if (r <= 4)      a = 8'h80 + 8'(r);
            else if (r == 5) a = 8'h90;
            else             a = 8'($urandom);
            step(a, 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : sw);
        end

        // Reset in the middle of slot 2.
        guard = 0;
        while (((m_edges / DIV) % 4) != 2 && guard < 40) begin
            idle(1);
            guard++;
        end
        check("slot2_reached", (guard < 40) ? 32'd1 : 32'd0, 32'd1);
        idle(1);
        do_reset(2);
        step(8'h80, 8'h00, 1'b0, sw);
        check("restart_an", {28'b0, an}, 32'hE);
        step(8'h84, 8'h00, 1'b0, sw);
        step(8'h83, 8'h00, 1'b0, sw);
        idle(4 * DIV);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
